// File: rtl/regfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Address width for a given depth; at least one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 0) || (rd_lat == 1);
    endfunction

    function automatic bit ports_ok(input int n_rd, input int n_wr);
        return (n_rd >= 1) && (n_wr >= 1);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Hardware clear sequencer: walks every entry once, writing zero.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for clr_req; busy low, no clear writes
//   ST_CLEAR | zeroing entry[cnt] each cycle; busy high for DEPTH cycles
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    // State and counter register; reset aborts any clear in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and outputs; clr_req is ignored once a clear is running.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write priority, optional
// zero register, optional bypass, optional registered reads and a
// hardware clear sequencer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 16,
    parameter int  N_RD     = 2,
    parameter int  N_WR     = 2,
    parameter int  ZERO_REG = 0,
    parameter int  BYPASS   = 1,
    parameter int  RD_LAT   = 0,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_WR-1:0]        we,
    input  logic [N_WR*AW-1:0]     waddr,
    input  logic [N_WR*DATA_W-1:0] wdata,
    input  logic [N_RD*AW-1:0]     raddr,
    output logic [N_RD*DATA_W-1:0] rdata,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   wr_drop
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be a power of two and at least 2");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("regfile_mp: RD_LAT must be 0 or 1");
    end
    if (!ports_ok(N_RD, N_WR)) begin : g_bad_ports
        $error("regfile_mp: N_RD and N_WR must be at least 1");
    end

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [N_WR-1:0]        wr_ok;
    logic                   clr_we;
    logic [AW-1:0]          clr_addr;
    logic [N_RD*DATA_W-1:0] rd_val;

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write port is accepted when enabled, not blocked by a clear, and not
    // aimed at the hardwired zero entry.
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < N_WR; i++) begin
            wr_ok[i] = we[i] && !busy &&
                       !((ZERO_REG != 0) && (waddr[i*AW +: AW] == '0));
        end
    end

    assign wr_drop = busy & (|we);

    // Storage update; later ports overwrite earlier ones so the highest
    // index wins an address conflict. Clear writes and port writes never
    // coincide because ports are blocked while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end
            for (int i = 0; i < N_WR; i++) begin
                if (wr_ok[i]) begin
                    mem[waddr[i*AW +: AW]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] val;

        assign ra = raddr[j*AW +: AW];

        // Read mux: array contents, overridden by the winning accepted write
        // when bypassing, and forced to zero for the hardwired entry.
        always_comb begin
            val = mem[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < N_WR; i++) begin
                    if (wr_ok[i] && (waddr[i*AW +: AW] == ra)) begin
                        val = wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                val = '0;
            end
        end

        assign rd_val[j*DATA_W +: DATA_W] = val;
    end

    if (RD_LAT == 1) begin : g_rd_reg
        logic [N_RD*DATA_W-1:0] rd_q;

        // Registered read data, captured every edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_val;
            end
        end

        assign rdata = rd_q;
    end else begin : g_rd_comb
        assign rdata = rd_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four instances sharing stimulus, covering
// the default build, no-bypass, registered reads and the zero register.
`timescale 1ns/1ps
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [3:0]  waddr0, waddr1, raddr0, raddr1;
    logic [7:0]  wdata0, wdata1;
    logic        clr_req;

    logic [7:0]  waddr_bus, raddr_bus;
    logic [15:0] wdata_bus;

    logic [15:0] rdata_d, rdata_nb, rdata_rl, rdata_zr;
    logic        busy_d, busy_nb, busy_rl, busy_zr;
    logic        drop_d, drop_nb, drop_rl, drop_zr;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cnt;

    assign waddr_bus = {waddr1, waddr0};
    assign raddr_bus = {raddr1, raddr0};
    assign wdata_bus = {wdata1, wdata0};

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr_bus), .wdata(wdata_bus),
        .raddr(raddr_bus), .rdata(rdata_d), .clr_req(clr_req), .busy(busy_d), .wr_drop(drop_d)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr_bus), .wdata(wdata_bus),
        .raddr(raddr_bus), .rdata(rdata_nb), .clr_req(clr_req), .busy(busy_nb), .wr_drop(drop_nb)
    );

    regfile_mp #(.RD_LAT(1)) u_rl (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr_bus), .wdata(wdata_bus),
        .raddr(raddr_bus), .rdata(rdata_rl), .clr_req(clr_req), .busy(busy_rl), .wr_drop(drop_rl)
    );

    regfile_mp #(.ZERO_REG(1)) u_zr (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr_bus), .wdata(wdata_bus),
        .raddr(raddr_bus), .rdata(rdata_zr), .clr_req(clr_req), .busy(busy_zr), .wr_drop(drop_zr)
    );

    function automatic logic [31:0] port(input logic [15:0] bus, input int j);
        return 32'(bus[j*8 +: 8]);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        we      = '0;
        waddr0  = '0; waddr1 = '0;
        wdata0  = '0; wdata1 = '0;
        raddr0  = '0; raddr1 = '0;
        clr_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset contents: every address reads zero, clear idle.
        for (int a = 0; a < 16; a++) begin
            raddr0 = 4'(a);
            raddr1 = 4'(15 - a);
            @(negedge clk);
            check($sformatf("rst_rd0_a%0d", a), port(rdata_d, 0), 32'h00);
            check($sformatf("rst_rd1_a%0d", 15 - a), port(rdata_d, 1), 32'h00);
            check($sformatf("rst_rl_a%0d", a), port(rdata_rl, 0), 32'h00);
            tick();
        end
        @(negedge clk);
        check("rst_busy", 32'(busy_d), 32'h0);

        // Same-address conflict: port 1 must win, also through the bypass.
        tick();
        we = 2'b11; waddr0 = 4'd5; waddr1 = 4'd5; wdata0 = 8'h11; wdata1 = 8'h22;
        raddr0 = 4'd5;
        @(negedge clk);
        check("conflict_bypass", port(rdata_d, 0), 32'h22);
        check("conflict_nb_old", port(rdata_nb, 0), 32'h00);
        tick();
        we = '0;
        @(negedge clk);
        check("conflict_stored", port(rdata_d, 0), 32'h22);
        check("conflict_nb_new", port(rdata_nb, 0), 32'h22);
        check("conflict_rl_byp", port(rdata_rl, 0), 32'h22);

        // Same-cycle read of a write: bypass vs old contents.
        tick();
        we = 2'b01; waddr0 = 4'd3; wdata0 = 8'hA5; raddr0 = 4'd3;
        @(negedge clk);
        check("bypass_same_cyc", port(rdata_d, 0), 32'hA5);
        check("nobyp_same_cyc", port(rdata_nb, 0), 32'h00);
        tick();
        we = '0;
        @(negedge clk);
        check("nobyp_next_cyc", port(rdata_nb, 0), 32'hA5);
        check("bypass_next_cyc", port(rdata_d, 0), 32'hA5);

        // Registered reads: data appears one edge after raddr.
        tick();
        we = 2'b01; waddr0 = 4'd7; wdata0 = 8'h3C; raddr0 = 4'd5;
        tick();
        we = '0; raddr0 = 4'd7;
        @(negedge clk);
        check("rl_hold_prev", port(rdata_rl, 0), 32'h22);
        check("comb_rd_a7", port(rdata_d, 0), 32'h3C);
        tick();
        @(negedge clk);
        check("rl_rd_a7", port(rdata_rl, 0), 32'h3C);

        // Reset clears the read register and the array.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rl_after_rst", port(rdata_rl, 0), 32'h00);
        check("comb_after_rst", port(rdata_d, 0), 32'h00);

        // Fill every entry with 0xFF.
        for (int a = 0; a < 16; a += 2) begin
            tick();
            we = 2'b11; waddr0 = 4'(a); waddr1 = 4'(a + 1); wdata0 = 8'hFF; wdata1 = 8'hFF;
        end
        tick();
        we = '0; raddr0 = 4'd15; raddr1 = 4'd0;
        @(negedge clk);
        check("fill_a15", port(rdata_d, 0), 32'hFF);
        check("fill_a0", port(rdata_d, 1), 32'hFF);
        check("zr_fill_a0", port(rdata_zr, 1), 32'h00);

        // Clear sequence: count busy cycles, drop a write in cycle 4,
        // re-request mid-clear (must not restart).
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 4) begin
                we = 2'b01; waddr0 = 4'd1; wdata0 = 8'h5A; raddr0 = 4'd15; raddr1 = 4'd1;
            end
            if (c == 8) clr_req = 1'b1;
            @(negedge clk);
            if (!busy_d) break;
            busy_cnt++;
            if (c == 4) begin
                check("clr_wr_drop", 32'(drop_d), 32'h1);
                check("clr_mid_a15", port(rdata_d, 0), 32'hFF);
                check("clr_drop_no_byp", port(rdata_d, 1), 32'h00);
            end
            tick();
            we = '0;
            clr_req = 1'b0;
        end
        check("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            raddr0 = 4'(a);
            #1;
            check($sformatf("clr_done_a%0d", a), port(rdata_d, 0), 32'h00);
        end

        // Zero register: writes to entry 0 vanish without wr_drop.
        tick();
        we = 2'b01; waddr0 = 4'd0; wdata0 = 8'h77; raddr0 = 4'd0;
        @(negedge clk);
        check("zr_same_cyc", port(rdata_zr, 0), 32'h00);
        check("zr_no_drop", 32'(drop_zr), 32'h0);
        tick();
        we = '0;
        @(negedge clk);
        check("zr_after", port(rdata_zr, 0), 32'h00);
        check("nozr_after", port(rdata_d, 0), 32'h77);

        // Reset in the middle of a clear aborts it and zeroes everything.
        tick();
        we = 2'b11; waddr0 = 4'd12; waddr1 = 4'd13; wdata0 = 8'hFF; wdata1 = 8'hFF;
        tick();
        we = '0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (4) tick();
        raddr0 = 4'd12;
        @(negedge clk);
        check("midclr_busy", 32'(busy_d), 32'h1);
        check("midclr_a12", port(rdata_d, 0), 32'hFF);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_d), 32'h0);
        check("abort_busy_zr", 32'(busy_zr), 32'h0);
        for (int a = 0; a < 16; a++) begin
            raddr0 = 4'(a);
            #1;
            check($sformatf("abort_a%0d", a), port(rdata_d, 0), 32'h00);
        end
        repeat (3) tick();
        @(negedge clk);
        check("abort_stays_idle", 32'(busy_d), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
